// File: rtl/axis_uart_pkg.sv
// Shared definitions for the AXI-Stream to UART TX path.
// Holds the default sizes and the {last,data} beat layout.
package axis_uart_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LEN_W = 8;

  typedef struct packed {
    logic                 last;
    logic [DEF_WIDTH-1:0] data;
  } axis_beat_t;

  // A stored beat is the data word with the TLAST flag on top
  function automatic int beat_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a registered level and a combinational head.
// Writes while full and reads while empty are ignored; clr flushes everything.
module axis_sync_fifo
  import axis_uart_pkg::*;
#(
  parameter int WIDTH = beat_width(DEF_WIDTH),
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full && !clr;
  assign do_rd   = rd_en && !empty && !clr;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      level <= level + LW'(1);
      else if (do_rd && !do_wr) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/axis_pkt_source.sv
// AXI-Stream master source: loader bytes are buffered, framed into packets
// by beat count or explicit flag, and presented through an output register.
module axis_pkt_source
  import axis_uart_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [LEN_W-1:0]       pkt_len,
  input  logic [WIDTH-1:0]       load_data,
  input  logic                   load_last,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic [WIDTH-1:0]       m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   pkt_sent
);

  localparam int BW = beat_width(WIDTH);

  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] eff_len;
  logic             last_bit;
  logic             wr_en;
  logic             rd_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BW-1:0]    head;

  assign load_ready = !fifo_full;
  assign wr_en      = load_valid && load_ready;

  // The first beat of a packet uses the live pkt_len; later beats use the latched copy
  assign eff_len  = (beat == '0) ? pkt_len : len_q;
  assign last_bit = load_last || ((eff_len != '0) && (beat == eff_len - LEN_W'(1)));

  assign rd_en = !fifo_empty && (!m_axis_tvalid || m_axis_tready);

  axis_sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data ({last_bit, load_data}),
    .rd_en   (rd_en),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat  <= '0;
      len_q <= '0;
    end else if (clr) begin
      beat  <= '0;
      len_q <= '0;
    end else if (wr_en) begin
      if (beat == '0) len_q <= pkt_len;
      beat <= last_bit ? '0 : beat + LEN_W'(1);
    end
  end

  // Output register only reloads when empty or when the sink takes the current beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      pkt_sent      <= 1'b0;
    end else if (clr) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      pkt_sent      <= 1'b0;
    end else begin
      pkt_sent <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (rd_en) begin
        m_axis_tdata  <= head[WIDTH-1:0];
        m_axis_tlast  <= head[WIDTH];
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_source.sv
// Directed bench for axis_pkt_source: framing, back-pressure, full FIFO,
// stall stability, clr flush and asynchronous reset recovery.
module tb_axis_pkt_source;
  import axis_uart_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LEN_W = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clr;
  logic [LEN_W-1:0]       pkt_len;
  logic [WIDTH-1:0]       load_data;
  logic                   load_last;
  logic                   load_valid;
  logic                   load_ready;
  logic [WIDTH-1:0]       m_axis_tdata;
  logic                   m_axis_tlast;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   pkt_sent;

  int         passCount = 0;
  int         checkCount = 0;
  int         failCount = 0;
  int         pktSentCount = 0;
  bit         stallCheckEn = 1'b0;
  axis_beat_t rxQ[$];
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic       prevLast = 1'b0;
  logic [7:0] prevData = '0;
  logic       expLast4 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  axis_pkt_source #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .pkt_len       (pkt_len),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .pkt_sent      (pkt_sent)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    load_data  = d;
    load_last  = l;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic checkRx(input string tag, input int idx, input logic [7:0] d, input logic l);
    if (idx < rxQ.size()) begin
      checkOutput($sformatf("%s[%0d].data", tag, idx), rxQ[idx].data, d);
      checkOutput($sformatf("%s[%0d].last", tag, idx), rxQ[idx].last, l);
    end else begin
      checkOutput($sformatf("%s[%0d].present", tag, idx), rxQ.size(), idx + 1);
    end
  endtask

  // Sink-side monitor plus the AXIS hold rule, sampled on the falling edge
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      rxQ.push_back(axis_beat_t'{last: m_axis_tlast, data: m_axis_tdata});
    if (pkt_sent) pktSentCount++;
    if (stallCheckEn && prevValid && !prevReady) begin
      checkOutput("stall_tvalid", m_axis_tvalid, 1);
      checkOutput("stall_tdata", m_axis_tdata, prevData);
      checkOutput("stall_tlast", m_axis_tlast, prevLast);
    end
    prevValid = m_axis_tvalid;
    prevReady = m_axis_tready;
    prevLast  = m_axis_tlast;
    prevData  = m_axis_tdata;
  end

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    pkt_len       = '0;
    load_data     = '0;
    load_last     = 1'b0;
    load_valid    = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) tick();
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_tlast", m_axis_tlast, 0);
    checkOutput("rst_pkt_sent", pkt_sent, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_load_ready", load_ready, 1);
    rst = 1'b0;
    tick();

    // Packets of 4 with a partial second packet
    $display("[TB] packet length 4");
    pkt_len = 8'd4;
    m_axis_tready = 1'b1;
    rxQ.delete();
    pktSentCount = 0;
    applyStimulus(8'h48, 1'b0);
    checkOutput("t1_first_tvalid", m_axis_tvalid, 0);
    checkOutput("t1_first_level", fifo_level, 1);
    applyStimulus(8'h45, 1'b0);
    checkOutput("t1_lat_tvalid", m_axis_tvalid, 1);
    checkOutput("t1_lat_tdata", m_axis_tdata, 8'h48);
    checkOutput("t1_rw_level", fifo_level, 1);
    applyStimulus(8'h4C, 1'b0);
    applyStimulus(8'h4C, 1'b0);
    applyStimulus(8'h4F, 1'b0);
    applyStimulus(8'h0A, 1'b0);
    repeat (4) tick();
    checkOutput("t1_rx_count", rxQ.size(), 6);
    checkRx("t1", 0, 8'h48, 1'b0);
    checkRx("t1", 1, 8'h45, 1'b0);
    checkRx("t1", 2, 8'h4C, 1'b0);
    checkRx("t1", 3, 8'h4C, 1'b1);
    checkRx("t1", 4, 8'h4F, 1'b0);
    checkRx("t1", 5, 8'h0A, 1'b0);
    checkOutput("t1_pkt_sent_count", pktSentCount, 1);
    checkOutput("t1_drained_tvalid", m_axis_tvalid, 0);
    checkOutput("t1_drained_level", fifo_level, 0);

    // Explicit TLAST with auto framing off, then beat counter restart
    $display("[TB] explicit last");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pkt_len = 8'd0;
    rxQ.delete();
    pktSentCount = 0;
    applyStimulus(8'hA1, 1'b0);
    applyStimulus(8'hB2, 1'b0);
    applyStimulus(8'hC3, 1'b1);
    repeat (3) tick();
    pkt_len = 8'd2;
    applyStimulus(8'hD4, 1'b0);
    applyStimulus(8'hE5, 1'b0);
    repeat (4) tick();
    checkOutput("t2_rx_count", rxQ.size(), 5);
    checkRx("t2", 0, 8'hA1, 1'b0);
    checkRx("t2", 1, 8'hB2, 1'b0);
    checkRx("t2", 2, 8'hC3, 1'b1);
    checkRx("t2", 3, 8'hD4, 1'b0);
    checkRx("t2", 4, 8'hE5, 1'b1);
    checkOutput("t2_pkt_sent_count", pktSentCount, 2);

    // Fill to capacity under back-pressure, then drain at full rate
    $display("[TB] full fifo");
    m_axis_tready = 1'b0;
    pkt_len = 8'd0;
    rxQ.delete();
    stallCheckEn = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i), 1'b0);
    checkOutput("t3_level15", fifo_level, 15);
    checkOutput("t3_ready_before_full", load_ready, 1);
    applyStimulus(8'h20, 1'b0);
    checkOutput("t3_level_full", fifo_level, 16);
    checkOutput("t3_ready_full", load_ready, 0);
    checkOutput("t3_tvalid_held", m_axis_tvalid, 1);
    checkOutput("t3_tdata_held", m_axis_tdata, 8'h10);
    load_data  = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    checkOutput("t3_no_overwrite_level", fifo_level, 16);
    checkOutput("t3_no_overwrite_tdata", m_axis_tdata, 8'h10);
    m_axis_tready = 1'b1;
    repeat (17) tick();
    checkOutput("t3_rx_count", rxQ.size(), 17);
    checkOutput("t3_drained_tvalid", m_axis_tvalid, 0);
    for (int i = 0; i < 17; i++) checkRx("t3", i, 8'(8'h10 + i), 1'b0);

    // Random sink stalls while packets of 3 flow
    $display("[TB] random stalls");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pkt_len = 8'd3;
    rxQ.delete();
    for (int i = 0; i < 8; i++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      applyStimulus(8'(8'h60 + i), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (12) tick();
    stallCheckEn = 1'b0;
    checkOutput("t4_rx_count", rxQ.size(), 8);
    for (int i = 0; i < 8; i++) checkRx("t4", i, 8'(8'h60 + i), expLast4[i]);

    // Flush with a queued backlog and a pending output beat
    $display("[TB] clear");
    m_axis_tready = 1'b0;
    pkt_len = 8'd4;
    rxQ.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h31 + i), 1'b0);
    checkOutput("t5_level_before", fifo_level, 5);
    checkOutput("t5_tvalid_before", m_axis_tvalid, 1);
    clr        = 1'b1;
    load_data  = 8'hEE;
    load_valid = 1'b1;
    tick();
    clr        = 1'b0;
    load_valid = 1'b0;
    checkOutput("t5_tvalid", m_axis_tvalid, 0);
    checkOutput("t5_level", fifo_level, 0);
    checkOutput("t5_load_ready", load_ready, 1);
    checkOutput("t5_tdata", m_axis_tdata, 0);
    m_axis_tready = 1'b1;
    pkt_len = 8'd2;
    applyStimulus(8'h71, 1'b0);
    applyStimulus(8'h72, 1'b0);
    repeat (4) tick();
    checkOutput("t5_rx_count", rxQ.size(), 2);
    checkRx("t5", 0, 8'h71, 1'b0);
    checkRx("t5", 1, 8'h72, 1'b1);

    // Asynchronous reset in the middle of a packet
    $display("[TB] async reset");
    m_axis_tready = 1'b0;
    pkt_len = 8'd4;
    rxQ.delete();
    applyStimulus(8'h81, 1'b0);
    applyStimulus(8'h82, 1'b0);
    applyStimulus(8'h83, 1'b0);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_tvalid", m_axis_tvalid, 0);
    checkOutput("t6_tdata", m_axis_tdata, 0);
    checkOutput("t6_tlast", m_axis_tlast, 0);
    checkOutput("t6_level", fifo_level, 0);
    checkOutput("t6_load_ready", load_ready, 1);
    checkOutput("t6_pkt_sent", pkt_sent, 0);
    tick();
    rst = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    pkt_len = 8'd2;
    applyStimulus(8'h91, 1'b0);
    applyStimulus(8'h92, 1'b0);
    repeat (4) tick();
    checkOutput("t6_rx_count", rxQ.size(), 2);
    checkRx("t6", 0, 8'h91, 1'b0);
    checkRx("t6", 1, 8'h92, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
